// File: rtl/pcu_pkg.sv
// Shared definitions for the pipelined main control unit: opcodes, ALU-op
// encodings, the control bundle and its per-stage slices.
// Optional feature macro: PCU_JUMP_EN (adds the j opcode).
package pcu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef PCU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_bundle_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  function automatic ex_ctrl_t ex_slice(input ctrl_bundle_t b);
    return '{reg_dst: b.reg_dst, alu_src: b.alu_src, alu_op: b.alu_op};
  endfunction

  function automatic mem_ctrl_t mem_slice(input ctrl_bundle_t b);
    return '{branch: b.branch, mem_read: b.mem_read, mem_write: b.mem_write};
  endfunction

  function automatic wb_ctrl_t wb_slice(input ctrl_bundle_t b);
    return '{mem_to_reg: b.mem_to_reg, reg_write: b.reg_write};
  endfunction

endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational opcode decoder: produces the control bundle for the ID-stage
// instruction, whether it reads rt, and an illegal-opcode flag.
// Optional feature macro: PCU_JUMP_EN (j decodes as a bubble plus jump flag).
module pcu_decoder
  import pcu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
`ifdef PCU_JUMP_EN
  output logic                jump,
`endif
  output ctrl_bundle_t        bundle,
  output logic                uses_rt,
  output logic                illegal
);

  logic known;
  logic jump_op;

  // Table lookup; an invalid slot or unknown opcode yields the bubble bundle.
  always_comb begin
    bundle  = CTRL_BUBBLE;
    uses_rt = 1'b0;
    known   = 1'b1;
    jump_op = 1'b0;
    case (opcode)
      OPCODE_W'(OP_RTYPE): begin
        bundle  = '{1'b1, 1'b0, ALU_FUNCT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        uses_rt = 1'b1;
      end
      OPCODE_W'(OP_LW):   bundle = '{1'b0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      OPCODE_W'(OP_SW): begin
        bundle  = '{1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        uses_rt = 1'b1;
      end
      OPCODE_W'(OP_BEQ): begin
        bundle  = '{1'b0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        uses_rt = 1'b1;
      end
      OPCODE_W'(OP_ADDI): bundle = '{1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OPCODE_W'(OP_ANDI): bundle = '{1'b0, 1'b1, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OPCODE_W'(OP_ORI):  bundle = '{1'b0, 1'b1, ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      OPCODE_W'(OP_SLTI): bundle = '{1'b0, 1'b1, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef PCU_JUMP_EN
      OPCODE_W'(OP_J):    jump_op = 1'b1;
`endif
      default:            known = 1'b0;
    endcase
    if (!id_valid) begin
      bundle = CTRL_BUBBLE;
    end
  end

  assign illegal = id_valid & ~known;
`ifdef PCU_JUMP_EN
  assign jump    = id_valid & jump_op;
`endif

endmodule

// File: rtl/pipelined_control_unit.sv
// Main control for the 5-stage pipeline: decodes in ID and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with load-use bubble insertion,
// external freeze and branch flush.
// Optional feature macro: PCU_JUMP_EN (adds jump_id output).
module pipelined_control_unit
  import pcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] opcode_id,
  input  logic [REG_W-1:0]    rs_id,
  input  logic [REG_W-1:0]    rt_id,
  input  logic                ext_stall,
  input  logic                flush,
`ifdef PCU_JUMP_EN
  output logic                jump_id,
`endif
  output logic                load_use_stall,
  output logic                illegal_id,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rt,
  output logic                mem_branch,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write
);

  ctrl_bundle_t dec_bundle;
  logic         dec_uses_rt;

  // ID/EX register contents
  ex_ctrl_t     idex_ex;
  mem_ctrl_t    idex_mem;
  wb_ctrl_t     idex_wb;
  logic [REG_W-1:0] idex_rt;
  // EX/MEM register contents
  mem_ctrl_t    exmem_mem;
  wb_ctrl_t     exmem_wb;
  // MEM/WB register contents
  wb_ctrl_t     memwb_wb;

  pcu_decoder #(.OPCODE_W(OPCODE_W)) u_decoder (
    .opcode   (opcode_id),
    .id_valid (id_valid),
`ifdef PCU_JUMP_EN
    .jump     (jump_id),
`endif
    .bundle   (dec_bundle),
    .uses_rt  (dec_uses_rt),
    .illegal  (illegal_id)
  );

  // A load in EX whose destination feeds the ID instruction forces one bubble.
  assign load_use_stall = id_valid & idex_mem.mem_read & (idex_rt != '0) &
                          ((idex_rt == rs_id) | (dec_uses_rt & (idex_rt == rt_id)));

  // Stage registers: freeze > flush > load-use bubble > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      idex_rt   <= '0;
      exmem_mem <= '0;
      exmem_wb  <= '0;
      memwb_wb  <= '0;
    end else if (!ext_stall) begin
      memwb_wb <= exmem_wb;
      if (flush) begin
        exmem_mem <= '0;
        exmem_wb  <= '0;
      end else begin
        exmem_mem <= idex_mem;
        exmem_wb  <= idex_wb;
      end
      if (flush || load_use_stall) begin
        idex_ex  <= '0;
        idex_mem <= '0;
        idex_wb  <= '0;
        idex_rt  <= '0;
      end else begin
        idex_ex  <= ex_slice(dec_bundle);
        idex_mem <= mem_slice(dec_bundle);
        idex_wb  <= wb_slice(dec_bundle);
        // Bubbles (invalid, illegal, jump) carry rt = 0 as well.
        idex_rt  <= (dec_bundle != CTRL_BUBBLE) ? rt_id : '0;
      end
    end
  end

  assign ex_reg_dst    = idex_ex.reg_dst;
  assign ex_alu_src    = idex_ex.alu_src;
  assign ex_alu_op     = ALUOP_W'(idex_ex.alu_op);
  assign ex_rt         = idex_rt;
  assign mem_branch    = exmem_mem.branch;
  assign mem_mem_read  = exmem_mem.mem_read;
  assign mem_mem_write = exmem_mem.mem_write;
  assign wb_mem_to_reg = memwb_wb.mem_to_reg;
  assign wb_reg_write  = memwb_wb.reg_write;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: a three-slot pipeline model
// plus directed vectors with literal expectations.
// Optional feature macro: PCU_JUMP_EN (checks jump_id).
module tb_pipelined_control_unit;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, ANDI = 6'b001100,
                         ORI = 6'b001101, SLTI = 6'b001010, JMP = 6'b000010,
                         BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] opcode_id = '0;
  logic [4:0] rs_id = '0, rt_id = '0;
  logic       ext_stall = 1'b0, flush = 1'b0;
  logic       load_use_stall, illegal_id;
  logic       ex_reg_dst, ex_alu_src;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_rt;
  logic       mem_branch, mem_mem_read, mem_mem_write;
  logic       wb_mem_to_reg, wb_reg_write;
`ifdef PCU_JUMP_EN
  logic       jump_id;
`endif

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode_id(opcode_id),
    .rs_id(rs_id), .rt_id(rt_id), .ext_stall(ext_stall), .flush(flush),
`ifdef PCU_JUMP_EN
    .jump_id(jump_id),
`endif
    .load_use_stall(load_use_stall), .illegal_id(illegal_id),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model. Entry = {rt[4:0], reg_dst, alu_src, alu_op[2:0], branch,
  // mem_read, mem_write, mem_to_reg, reg_write}; slots 0=EX, 1=MEM, 2=WB.
  logic [14:0] exp_q[$] = '{15'd0, 15'd0, 15'd0};
  logic [14:0] m_nx;
  logic [9:0]  m_b;

  function automatic logic [9:0] m_decode(input logic v, input logic [5:0] op);
    if (!v) return 10'd0;
    case (op)
      R:       return 10'b1_0_010_0_0_0_0_1;
      LW:      return 10'b0_1_000_0_1_0_1_1;
      SW:      return 10'b0_1_000_0_0_1_0_0;
      BEQ:     return 10'b0_0_001_1_0_0_0_0;
      ADDI:    return 10'b0_1_000_0_0_0_0_1;
      ANDI:    return 10'b0_1_011_0_0_0_0_1;
      ORI:     return 10'b0_1_100_0_0_0_0_1;
      SLTI:    return 10'b0_1_101_0_0_0_0_1;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic m_illegal();
    logic known;
    known = (m_decode(1'b1, opcode_id) != 10'd0);
`ifdef PCU_JUMP_EN
    if (opcode_id == JMP) known = 1'b1;
`endif
    return id_valid && !known;
  endfunction

  function automatic logic m_stall();
    logic [14:0] e;
    logic        urt;
    e   = exp_q[0];
    urt = (opcode_id == R) || (opcode_id == SW) || (opcode_id == BEQ);
    return id_valid && e[3] && (e[14:10] != 5'd0) &&
           ((e[14:10] == rs_id) || (urt && (e[14:10] == rt_id)));
  endfunction

  // Model pipeline update on each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q = '{15'd0, 15'd0, 15'd0};
    end else if (!ext_stall) begin
      if (flush) begin
        exp_q[2] = exp_q[1];
        exp_q[1] = 15'd0;
        exp_q[0] = 15'd0;
      end else begin
        m_b  = m_decode(id_valid, opcode_id);
        m_nx = (m_stall() || m_b == 10'd0) ? 15'd0 : {rt_id, m_b};
        exp_q.push_front(m_nx);
        void'(exp_q.pop_back());
      end
    end
  end

  // Compare process: every cycle, mid-period.
  logic [14:0] c_ex, c_mem, c_wb;
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      c_ex  = exp_q[0];
      c_mem = exp_q[1];
      c_wb  = exp_q[2];
      check("ex_stage", {24'd0, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt},
            {24'd0, c_ex[9:5], c_ex[14:10]});
      check("mem_stage", {29'd0, mem_branch, mem_mem_read, mem_mem_write}, {29'd0, c_mem[4:2]});
      check("wb_stage", {30'd0, wb_mem_to_reg, wb_reg_write}, {30'd0, c_wb[1:0]});
      check("id_comb", {30'd0, load_use_stall, illegal_id}, {30'd0, m_stall(), m_illegal()});
`ifdef PCU_JUMP_EN
      check("jump_id", {31'd0, jump_id}, {31'd0, id_valid && opcode_id == JMP});
`endif
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic es, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; opcode_id = op; rs_id = rs; rt_id = rt; ext_stall = es; flush = fl;
  endtask

  task automatic nop();
    drive(1'b0, R, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_regs();
    return {16'd0, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, mem_branch,
            mem_mem_read, mem_mem_write, wb_mem_to_reg, wb_reg_write};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    sample();
    check("reset_regs", all_regs(), 32'd0);

    // lw latency through the stages
    drive(1'b1, LW, 5'd1, 5'd8, 1'b0, 1'b0);
    nop(); sample(); check("lw_ex_alu_src", {31'd0, ex_alu_src}, 32'd1);
    nop(); sample(); check("lw_mem_read", {31'd0, mem_mem_read}, 32'd1);
    nop(); sample(); check("lw_wb", {30'd0, wb_mem_to_reg, wb_reg_write}, 32'd3);

    // load-use: one stall cycle, one bubble
    drive(1'b1, LW, 5'd0, 5'd8, 1'b0, 1'b0);
    drive(1'b1, R, 5'd8, 5'd3, 1'b0, 1'b0);
    sample(); check("lu_stall", {31'd0, load_use_stall}, 32'd1);
    drive(1'b1, R, 5'd8, 5'd3, 1'b0, 1'b0);
    sample(); check("lu_bubble", {27'd0, load_use_stall, ex_reg_dst, ex_alu_op}, 32'd0);
    check("lu_bubble_rt", {27'd0, ex_rt}, 32'd0);
    nop(); sample(); check("lu_add_ex", {26'd0, ex_reg_dst, ex_rt}, {26'd0, 1'b1, 5'd3});
    // rt=0 never stalls; addi does not read rt
    drive(1'b1, LW, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, R, 5'd0, 5'd0, 1'b0, 1'b0);
    sample(); check("lu_rt0", {31'd0, load_use_stall}, 32'd0);
    drive(1'b1, LW, 5'd0, 5'd9, 1'b0, 1'b0);
    drive(1'b1, ADDI, 5'd2, 5'd9, 1'b0, 1'b0);
    sample(); check("lu_addi_rt", {31'd0, load_use_stall}, 32'd0);

    // branch flush: beq in MEM, ori in EX, addi in ID
    drive(1'b1, BEQ, 5'd1, 5'd2, 1'b0, 1'b0);
    drive(1'b1, ORI, 5'd3, 5'd4, 1'b0, 1'b0);
    drive(1'b1, ADDI, 5'd5, 5'd6, 1'b0, 1'b1);
    sample(); check("fl_pre", {28'd0, mem_branch, ex_alu_op}, {28'd0, 1'b1, 3'b100});
    nop(); sample();
    check("fl_post", {29'd0, ex_alu_src, mem_branch, wb_reg_write}, 32'd0);

    // ext_stall with flush held: frozen, flush acts after stall drops
    drive(1'b1, ADDI, 5'd1, 5'd7, 1'b0, 1'b0);
    drive(1'b1, ANDI, 5'd1, 5'd7, 1'b0, 1'b0);
    repeat (3) drive(1'b1, SLTI, 5'd1, 5'd7, 1'b1, 1'b1);
    drive(1'b1, SLTI, 5'd1, 5'd7, 1'b0, 1'b1);
    sample(); check("es_frozen", {24'd0, ex_alu_op, ex_rt}, {24'd0, 3'b011, 5'd7});
    nop(); sample(); check("es_flush", {28'd0, ex_alu_op, wb_reg_write}, {28'd0, 3'b000, 1'b1});

    // illegal / jump opcodes
    drive(1'b1, BAD, 5'd1, 5'd2, 1'b0, 1'b0);
    sample(); check("illegal_on", {31'd0, illegal_id}, 32'd1);
    drive(1'b0, BAD, 5'd1, 5'd2, 1'b0, 1'b0);
    sample(); check("illegal_bubble", {26'd0, illegal_id, ex_alu_src, ex_rt}, 32'd0);
    drive(1'b1, JMP, 5'd0, 5'd5, 1'b0, 1'b0);
    sample();
`ifdef PCU_JUMP_EN
    check("jump_on", {30'd0, jump_id, illegal_id}, 32'd2);
`else
    check("j_illegal", {31'd0, illegal_id}, 32'd1);
`endif
    nop(); sample(); check("j_bubble", {27'd0, ex_rt}, 32'd0);

    // sw and slti stream, checked by the model
    drive(1'b1, SW, 5'd2, 5'd4, 1'b0, 1'b0);
    drive(1'b1, SLTI, 5'd3, 5'd5, 1'b0, 1'b0);
    nop(); sample(); check("sw_mem_write", {31'd0, mem_mem_write}, 32'd1);
    nop();

    // asynchronous reset between edges
    drive(1'b1, R, 5'd1, 5'd2, 1'b0, 1'b0);
    drive(1'b1, LW, 5'd3, 5'd10, 1'b0, 1'b0);
    drive(1'b1, ADDI, 5'd1, 5'd11, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", all_regs(), 32'd0);
    #1 rst = 1'b0;
    nop(); nop(); sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
